// File: rtl/mdu_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_unit_pkg
// Shared definitions for the multiply/divide unit:
//   - 3-bit MDU operation codes used by the decoder and the MDU
//   - FSM state encodings of the MDU sequencer
//   - MduBusy/MduIdle and Stop/NoStop single-bit constants
//   - small op-classification helpers
// ---------------------------------------------------------------------------
package mdu_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    localparam logic MduBusy = 1'b1;
    localparam logic MduIdle = 1'b0;
    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_unit_core_step.sv
// ---------------------------------------------------------------------------
// mdu_core_step
// Combinational single radix-2 step shared by multiply and divide.
//   is_div    in  1      1 = restoring divide step, 0 = shift-add multiply step
//   hi        in  WIDTH  partial product high half / partial remainder
//   lo        in  WIDTH  multiplier bits still to consume / dividend+quotient
//   operand   in  WIDTH  multiplicand or divisor magnitude
//   next_hi   out WIDTH  updated high half
//   next_lo   out WIDTH  updated low half
// ---------------------------------------------------------------------------
module mdu_core_step
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           fits;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the {carry, hi, lo} pair right by one.
    // Divide: shift {hi, lo} left by one and subtract the divisor when the
    // widened partial remainder is large enough; the quotient bit enters lo.
    // The true difference is always below the divisor, so a WIDTH-bit
    // wrapping subtract yields it exactly.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            next_hi = fits ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
// Iterative multiply / divide / multiply-accumulate unit, one bit per cycle.
//   cpu_clk_50M  in  1        clock, rising edge
//   cpu_rst_n    in  1        asynchronous active-low reset
//   start_i      in  1        begin an operation (honoured in IDLE or DONE)
//   cancel_i     in  1        flush; aborts any operation, beats start_i
//   op_i         in  3        operation code (mdu_op_t)
//   opdata1_i    in  WIDTH    multiplicand / dividend
//   opdata2_i    in  WIDTH    multiplier / divisor
//   hilo_i       in  2*WIDTH  current {HI,LO}, base for MADD/MSUB
//   busy_o       out 1        high while calculating or fixing up
//   ready_o      out 1        one-cycle pulse when result_o is fresh
//   result_o     out 2*WIDTH  {HI,LO}; divide gives {remainder, quotient}
// ---------------------------------------------------------------------------
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               start_i,
    input  logic               cancel_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t         state;
    mdu_state_t         next_state;
    mdu_op_t            op_in;
    mdu_op_t            op;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] hilo;
    logic               sign1;
    logic               sign2;
    logic               div_zero;

    logic               accept;
    logic               in_sign1;
    logic               in_sign2;
    logic               in_div_zero;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] fix_result;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] signed_prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign op_in       = mdu_op_t'(op_i);
    assign accept      = start_i && !cancel_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_sign1    = is_signed_op(op_in) && opdata1_i[WIDTH-1];
    assign in_sign2    = is_signed_op(op_in) && opdata2_i[WIDTH-1];
    assign mag1        = in_sign1 ? -opdata1_i : opdata1_i;
    assign mag2        = in_sign2 ? -opdata2_i : opdata2_i;
    assign in_div_zero = is_div_op(op_in) && (opdata2_i == '0);

    mdu_core_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .is_div  (is_div_op(op)),
        .hi      (hi),
        .lo      (lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // State register.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and Moore outputs. A divide by zero skips CALC entirely;
    // DONE falls back to IDLE unless a new operation starts in that cycle.
    always_comb begin
        next_state = state;
        busy_o     = MduIdle;
        ready_o    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                ready_o = (state == ST_DONE);
                if (accept) begin
                    next_state = in_div_zero ? ST_FIX : ST_CALC;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                busy_o = MduBusy;
                if (count == CW'(1)) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                busy_o     = MduBusy;
                next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (cancel_i) begin
            next_state = ST_IDLE;
        end
    end

    // Sign fix-up of the unsigned magnitude result, accumulate, and the
    // divide-by-zero pattern, where lo still carries the raw dividend.
    always_comb begin
        prod        = {hi, lo};
        signed_prod = (sign1 ^ sign2) ? -prod : prod;
        quot        = (sign1 ^ sign2) ? -lo : lo;
        rem         = sign1 ? -hi : hi;
        fix_result  = signed_prod;
        case (op)
            OP_DIV, OP_DIVU:   fix_result = div_zero ? {lo, {WIDTH{1'b1}}} : {rem, quot};
            OP_MADD, OP_MADDU: fix_result = hilo + signed_prod;
            OP_MSUB, OP_MSUBU: fix_result = hilo - signed_prod;
            default:           fix_result = signed_prod;
        endcase
    end

    // Datapath registers: operands are captured once as magnitudes so the
    // inputs may change freely afterwards; a cancel never touches result_o.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            op       <= OP_MULT;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            hilo     <= '0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            div_zero <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op       <= op_in;
                        count    <= CW'(WIDTH);
                        hi       <= '0;
                        hilo     <= hilo_i;
                        sign1    <= in_sign1;
                        sign2    <= in_sign2;
                        div_zero <= in_div_zero;
                        if (is_div_op(op_in)) begin
                            lo      <= in_div_zero ? opdata1_i : mag1;
                            operand <= mag2;
                        end else begin
                            lo      <= mag2;
                            operand <= mag1;
                        end
                    end
                end
                ST_CALC: begin
                    hi    <= step_hi;
                    lo    <= step_lo;
                    count <= count - CW'(1);
                end
                ST_FIX: begin
                    if (!cancel_i) begin
                        result_o <= fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// ---------------------------------------------------------------------------
// tb_mdu_unit
// Self-checking bench for mdu_unit (WIDTH=32). Expected results come from a
// plain-arithmetic reference model; cycle 0 is the cycle in which start_i is
// high, and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int W = 32;

    logic           cpu_clk_50M = 1'b0;
    logic           cpu_rst_n   = 1'b0;
    logic           start_i     = 1'b0;
    logic           cancel_i    = 1'b0;
    logic [2:0]     op_i        = 3'd0;
    logic [W-1:0]   opdata1_i   = '0;
    logic [W-1:0]   opdata2_i   = '0;
    logic [2*W-1:0] hilo_i      = '0;
    logic           busy_o;
    logic           ready_o;
    logic [2*W-1:0] result_o;

    int total = 0;
    int bad   = 0;

    mdu_unit #(.WIDTH(W)) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .start_i     (start_i),
        .cancel_i    (cancel_i),
        .op_i        (op_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .hilo_i      (hilo_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .result_o    (result_o)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    // Reference model built from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hilo);
        longint     sa;
        longint     sb;
        longint     sq;
        longint     sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = ua * ub;
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            3'd4: begin p = sa * sb; return hilo + p; end
            3'd5: begin p = ua * ub; return hilo + p; end
            3'd6: begin p = sa * sb; return hilo - p; end
            default: begin p = ua * ub; return hilo - p; end
        endcase
        return p;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
        return ((op == 3'd2 || op == 3'd3) && b == 0) ? 2 : W + 2;
    endfunction

    // Launch one operation from just after a falling edge; scramble inputs
    // after the start edge and wait (bounded) for ready_o.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo, output logic [63:0] res,
                         output int lat, output bit overlap);
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i    = hilo;
        start_i   = 1'b1;
        @(posedge cpu_clk_50M);
        #1;
        start_i   = 1'b0;
        op_i      = 3'($urandom);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        hilo_i    = {$urandom, $urandom};
        lat       = 0;
        overlap   = 1'b0;
        while (lat < 100) begin
            @(negedge cpu_clk_50M);
            lat++;
            if (busy_o && ready_o) overlap = 1'b1;
            if (ready_o) break;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_mult_latency();
        logic [63:0] res;
        int lat;
        bit ov;
        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, res, lat, ov);
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("[TB] FAIL mult_result: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFE); end
        total++; if (lat !== 34) begin bad++; $display("[TB] FAIL mult_latency: got %0d expected 34", lat); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL mult_busy_ready_overlap: got %b expected 0", ov); end
        @(negedge cpu_clk_50M);
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL ready_single_pulse: got %b expected 0", ready_o); end
        repeat (3) @(negedge cpu_clk_50M);
        total++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("[TB] FAIL result_hold: got %h expected %h", result_o, 64'hFFFF_FFFF_FFFF_FFFE); end
    endtask

    task automatic test_div_cases();
        logic [63:0] res;
        int lat;
        bit ov;
        do_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'd0, res, lat, ov);
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("[TB] FAIL div_signed: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFD); end
        @(negedge cpu_clk_50M);
        do_op(3'd3, 32'd5, 32'd0, 64'd0, res, lat, ov);
        total++; if (res !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("[TB] FAIL divu_by_zero: got %h expected %h", res, 64'h0000_0005_FFFF_FFFF); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL div_zero_latency: got %0d expected 2", lat); end
        @(negedge cpu_clk_50M);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, res, lat, ov);
        total++; if (res !== 64'h0000_0000_8000_0000) begin bad++; $display("[TB] FAIL div_overflow: got %h expected %h", res, 64'h0000_0000_8000_0000); end
        @(negedge cpu_clk_50M);
        do_op(3'd2, 32'h0000_0007, 32'd0, 64'd0, res, lat, ov);
        total++; if (res !== 64'h0000_0007_FFFF_FFFF) begin bad++; $display("[TB] FAIL div_signed_by_zero: got %h expected %h", res, 64'h0000_0007_FFFF_FFFF); end
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_accumulate();
        logic [63:0] res;
        int lat;
        bit ov;
        do_op(3'd4, 32'd3, 32'd4, 64'd1, res, lat, ov);
        total++; if (res !== 64'd13) begin bad++; $display("[TB] FAIL madd: got %h expected %h", res, 64'd13); end
        @(negedge cpu_clk_50M);
        do_op(3'd7, 32'd1, 32'd1, 64'd0, res, lat, ov);
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL msubu: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFFF); end
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_busy_ignore();
        logic [63:0] exp;
        int lat;
        bit done;
        exp = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
        op_i = 3'd1; opdata1_i = 32'h1234_5678; opdata2_i = 32'h9ABC_DEF0; start_i = 1'b1;
        @(posedge cpu_clk_50M);
        #1 start_i = 1'b0;
        lat = 0;
        done = 1'b0;
        while (lat < 100 && !done) begin
            @(negedge cpu_clk_50M);
            lat++;
            if (ready_o) done = 1'b1;
            start_i = (lat == 5);
            if (lat == 5) begin op_i = 3'd3; opdata1_i = 32'd9; opdata2_i = 32'd0; end
        end
        start_i = 1'b0;
        total++; if (lat !== 34) begin bad++; $display("[TB] FAIL busy_ignore_latency: got %0d expected 34", lat); end
        total++; if (result_o !== exp) begin bad++; $display("[TB] FAIL busy_ignore_result: got %h expected %h", result_o, exp); end
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_cancel();
        logic [63:0] prev;
        bit busy10;
        bit seen;
        prev = result_o;
        op_i = 3'd1; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_1001; start_i = 1'b1;
        @(posedge cpu_clk_50M);
        #1 start_i = 1'b0;
        busy10 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge cpu_clk_50M);
            start_i = (k == 5);
            if (k == 10) begin busy10 = busy_o; cancel_i = 1'b1; end
        end
        @(negedge cpu_clk_50M);
        cancel_i = 1'b0;
        total++; if (busy10 !== 1'b1) begin bad++; $display("[TB] FAIL cancel_busy_before: got %b expected 1", busy10); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL cancel_busy_after: got %b expected 0", busy_o); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge cpu_clk_50M);
            if (ready_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL cancel_no_ready: got %b expected 0", seen); end
        total++; if (result_o !== prev) begin bad++; $display("[TB] FAIL cancel_result_kept: got %h expected %h", result_o, prev); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        bit ov;
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, res, lat, ov);
        total++; if (res !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("[TB] FAIL b2b_first: got %h expected %h", res, 64'hFFFF_FFFE_0000_0001); end
        do_op(3'd3, 32'd100, 32'd7, 64'd0, res, lat, ov);
        total++; if (res !== 64'h0000_0002_0000_000E) begin bad++; $display("[TB] FAIL b2b_second: got %h expected %h", res, 64'h0000_0002_0000_000E); end
        total++; if (lat !== 34) begin bad++; $display("[TB] FAIL b2b_latency: got %0d expected 34", lat); end
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] exp;
        logic [63:0] res;
        int lat;
        bit ov;
        for (int i = 0; i < 30; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
            hilo = {$urandom, $urandom};
            exp  = model(op, a, b, hilo);
            do_op(op, a, b, hilo, res, lat, ov);
            total++; if (res !== exp) begin bad++; $display("[TB] FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", op, a, b, res, exp); end
            total++; if (lat !== exp_lat(op, b)) begin bad++; $display("[TB] FAIL rand_latency op=%0d: got %0d expected %0d", op, lat, exp_lat(op, b)); end
            total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL rand_overlap: got %b expected 0", ov); end
            if ($urandom_range(0, 1) == 1) @(negedge cpu_clk_50M);
        end
        @(negedge cpu_clk_50M);
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [63:0] res;
        int lat;
        bit ov;
        op_i = 3'd2; opdata1_i = 32'h7000_0001; opdata2_i = 32'h0000_0003; start_i = 1'b1;
        @(posedge cpu_clk_50M);
        #1 start_i = 1'b0;
        repeat (20) @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ready: got %b expected 0", ready_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("[TB] FAIL midreset_result: got %h expected 0", result_o); end
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge cpu_clk_50M);
            if (ready_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_no_ready: got %b expected 0", seen); end
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, res, lat, ov);
        total++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("[TB] FAIL post_reset_mult: got %h expected %h", res, 64'hFFFF_FFFF_FFFF_FFF1); end
        @(negedge cpu_clk_50M);
    endtask

    initial begin
        test_reset();
        test_mult_latency();
        test_div_cases();
        test_accumulate();
        test_busy_ignore();
        test_cancel();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand width; HI/LO result is 2*WIDTH bits.
REQ-002 cpu_clk_50M  in  1  sole clock, rising edge.
REQ-003 cpu_rst_n  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 cancel_i  in  1  flush from exception/annul; aborts any operation.
REQ-006 op_i  in  3  operation code from the shared package.
REQ-007 opdata1_i  in  WIDTH  multiplicand or dividend (rs).
REQ-008 opdata2_i  in  WIDTH  multiplier or divisor (rt).
REQ-009 hilo_i  in  2*WIDTH  current {HI,LO}, already forwarded by EX; accumulate base for MADD/MSUB.
REQ-010 busy_o  out  1  high in CALC and FIX; EX ORs it into its stall request.
REQ-011 ready_o  out  1  one-cycle pulse in DONE.
REQ-012 result_o  out  2*WIDTH  {HI,LO} result.

Function
REQ-013 Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
REQ-015 IDLE/DONE with start_i=1 and cancel_i=0: latch operands, op_i and hilo_i; load count=WIDTH; go to CALC.
- Exception: divide op with opdata2_i=0 goes to FIX.
REQ-016 Signed ops convert operands to magnitudes at latch and record result signs.
REQ-017 CALC performs one radix-2 step per cycle:
- multiply: shift-add
- divide: restoring shift-subtract
- count decrements; at count=1, go to FIX.
REQ-018 FIX, one cycle:
- apply sign correction
- quotient sign = sign1 XOR sign2; remainder sign = sign1
- MADD/MADDU: result = hilo + product, modulo 2^(2*WIDTH)
- MSUB/MSUBU: result = hilo - product, modulo 2^(2*WIDTH)
- register result_o; go to DONE.
REQ-019 DONE asserts ready_o for exactly one cycle. It returns to IDLE unless a new start is accepted in that same cycle.
REQ-020 Latency: ready_o is high WIDTH+2 cycles after the start cycle.
- Divide by zero: 2 cycles.
REQ-021 Divide result layout: HI = remainder, LO = quotient.
REQ-022 Divide by zero: HI = opdata1, LO = all ones, for signed and unsigned.
REQ-023 Signed -2^(WIDTH-1) / -1: LO = 0x8000...0, HI = 0. No trap.
REQ-024 start_i while busy_o=1 is ignored.
REQ-025 cancel_i=1 in any state:
- next state IDLE
- no ready_o pulse
- result_o keeps its previous value
- cancel wins over a simultaneous start_i.
REQ-026 result_o holds its value until the next FIX. busy_o and ready_o are never high together.
REQ-027 Operand inputs and hilo_i may change after the start cycle without affecting the result.

Reset
REQ-028 On cpu_rst_n low, asynchronously:
- state = IDLE
- busy_o = 0, ready_o = 0
- result_o = 0
- count and all datapath registers = 0.
REQ-029 Reset asserted mid-operation aborts it with no ready_o pulse.

Structure
REQ-030 The shared defines/package holds:
- the 3-bit MDU op codes
- the FSM state encodings
- MduBusy/MduIdle constants, alongside the existing Stop/NoStop macros.
REQ-031 One sub-module, mdu_core_step: the combinational single-step add/subtract-shift datapath, instantiated once. FSM and sign handling stay in mdu_unit.

Verification
REQ-032 MULT 0xFFFFFFFF x 0x00000002, WIDTH=32 -> ready at cycle 34; result_o = 0xFFFFFFFF_FFFFFFFE.
REQ-033 DIV 0xFFFFFFF9 / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-034 DIVU 5 / 0 -> ready at cycle 2; HI = 5, LO = 0xFFFFFFFF.
REQ-035 MADD with hilo_i = 1, operands 3 and 4 -> result 13; MSUBU with hilo_i = 0, operands 1 and 1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-036 Start MULTU, then cancel_i at cycle 10 -> busy_o low at cycle 11; no ready_o; result_o unchanged. A start_i at cycle 5 during busy is ignored.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. Reset asserted at cycle 20 of a DIV -> all outputs 0 immediately.
